game_referee: RTL and testbench
===============================

// Module: game_referee
// PURPOSE
//  Parametrised game-rule engine for the PAC-MAN top level: per game tick it checks player/ghost
//  collisions for NUM_GHOSTS ghosts, handles dot/big-dot eating, power mode, lives and win/lose.
//  It keeps a saturating BCD score for the seven-segment digits. It sits between the character
//  controllers/tilemap and the renderer/SevenDisplay; it owns game_state.
// PARAMETERS
//  NUM_GHOSTS     4        number of ghosts checked (1..8)
//  COORD_W        10       pixel coordinate width, x and y
//  TILE_SIZE      16       collision box size in pixels
//  SCORE_DIGITS   6        BCD digits of score
//  LIVES          3        lives at reset (>=1)
//  POWER_TICKS    10       ticks power mode lasts after a big dot
//  DEATH_TICKS    4        ticks spent in DYING
//  MAX_DOTS       300      dots+big dots eaten to win
//  DOT_PTS_BCD    16'h0010 / BIGDOT_PTS_BCD 16'h0050 / GHOST_PTS_BCD 16'h0200  4-digit BCD awards
// PORTS
//  clk            in   1                  system clock
//  reset          in   1                  synchronous, active-high reset
//  tick           in   1                  one-clk game-update strobe (character clock edge)
//  start          in   1                  any direction key pressed
//  player_x/y     in   COORD_W            player position (pixels)
//  ghost_x/y      in   NUM_GHOSTS*COORD_W packed ghost positions, ghost i at [i*COORD_W +: COORD_W]
//  dot_hit        in   1                  player's tile holds a dot (tilemap lookup)
//  bigdot_hit     in   1                  player's tile holds a big dot
//  game_state     out  3                  0 STANDBY,1 PLAYING,2 POWER,3 DYING,4 GAMEOVER,5 WIN
//  dot_clear      out  1                  1-clk pulse: clear player's tile in dot/big-dot map
//  ghost_respawn  out  NUM_GHOSTS         1-clk pulses: send ghost i to spawn
//  player_respawn out  1                  1-clk pulse: send player to spawn
//  score_bcd      out  4*SCORE_DIGITS     BCD score, digit 0 at [3:0]
//  lives          out  $clog2(LIVES+1)    lives remaining
//  dots_eaten     out  $clog2(MAX_DOTS+1) dots eaten
//  busy           out  1                  score additions pending
//  tick_overrun   out  1                  sticky: tick arrived while busy
// BEHAVIOUR
//  Reset: state STANDBY, score 0, lives=LIVES, dots_eaten 0, counters 0, all pulses/flags 0.
//  Evaluation only on cycles with tick=1 and busy=0 (tick at cycle T); results registered at T+1.
//  tick with busy=1: ignored entirely, tick_overrun set (cleared only by reset).
//  STANDBY: start latched on any cycle; next tick with latch set -> PLAYING, latch cleared.
//  Collision i: |ghost_x[i]-player_x|<TILE_SIZE AND |ghost_y[i]-player_y|<TILE_SIZE, unsigned
//   absolute difference (no signed wrap).
//  PLAYING/POWER tick, in this priority:
//   1. any collision in PLAYING: lives-1; lives hits 0 -> GAMEOVER; else -> DYING, player_respawn
//      and all ghost_respawn bits pulse at T+1; dots/score not processed this tick.
//   2. collisions in POWER: each colliding ghost's respawn bit pulses; one GHOST_PTS add each.
//   3. dot_hit: dot_clear, dots_eaten+1, add DOT_PTS. else bigdot_hit: dot_clear, dots_eaten+1,
//      add BIGDOT_PTS, state POWER, power counter := POWER_TICKS (reload if already POWER).
//   4. POWER with no reload: counter-1; reaches 0 -> PLAYING at T+1.
//   5. dots_eaten reaching MAX_DOTS this tick -> WIN (GAMEOVER from step 1 wins over WIN).
//  DYING: collisions/dots ignored; after DEATH_TICKS ticks -> PLAYING.
//  GAMEOVER, WIN: terminal; only reset leaves; inputs ignored.
//  Score adds queued: dot/big-dot first, then ghosts ascending index; one BCD add per clk from
//   T+1; busy high T+1 .. last add cycle; up to NUM_GHOSTS+1 adds per tick.
//  BCD add ripples all digits with decimal carry; carry out of top digit -> score saturates all 9s.
//  reset mid-queue: pending adds discarded, busy 0 next cycle.
// TESTING
//  reset, start=1 for 1 clk, tick -> game_state 1, lives 3, score 0.
//  PLAYING, dot_hit=1, tick -> dot_clear pulse at T+1, score 000010, dots_eaten 1, busy 1 clk.
//  bigdot_hit, tick; ghosts 0,2 at player pos +5,+5; tick -> state 2; respawn 4'b0101; score +50
//   then +400 (busy 2 clk); 10 further ticks without big dot -> state 1 exactly on 10th.
//  ghost 1 at dx=16 (no hit) vs dx=15 (hit) in PLAYING; ghost at x=0, player x=1000 -> no hit.
//  3 collisions, each followed by 4 ticks -> states 3,1,3,1 then GAMEOVER, lives 0, respawn pulses.
//  score preset 999990, dot tick -> 999999 saturate; tick during busy -> dropped, tick_overrun=1.

Source files
------------

// File: rtl/game_referee.sv
// Rule engine for the PAC-MAN top level: collisions, dot eating, power mode, lives,
// win/lose and a saturating BCD score fed by a one-add-per-clock award queue.
module game_referee #(
  parameter int          NUM_GHOSTS     = 4,
  parameter int          COORD_W        = 10,
  parameter int          TILE_SIZE      = 16,
  parameter int          SCORE_DIGITS   = 6,
  parameter int          LIVES          = 3,
  parameter int          POWER_TICKS    = 10,
  parameter int          DEATH_TICKS    = 4,
  parameter int          MAX_DOTS       = 300,
  parameter logic [15:0] DOT_PTS_BCD    = 16'h0010,
  parameter logic [15:0] BIGDOT_PTS_BCD = 16'h0050,
  parameter logic [15:0] GHOST_PTS_BCD  = 16'h0200,
  localparam int         LW             = $clog2(LIVES + 1),
  localparam int         DW             = $clog2(MAX_DOTS + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tick,
  input  logic                            start,
  input  logic [COORD_W-1:0]              player_x,
  input  logic [COORD_W-1:0]              player_y,
  input  logic [NUM_GHOSTS*COORD_W-1:0]   ghost_x,
  input  logic [NUM_GHOSTS*COORD_W-1:0]   ghost_y,
  input  logic                            dot_hit,
  input  logic                            bigdot_hit,
  output logic [2:0]                      game_state,
  output logic                            dot_clear,
  output logic [NUM_GHOSTS-1:0]           ghost_respawn,
  output logic                            player_respawn,
  output logic [4*SCORE_DIGITS-1:0]       score_bcd,
  output logic [LW-1:0]                   lives,
  output logic [DW-1:0]                   dots_eaten,
  output logic                            busy,
  output logic                            tick_overrun
);

  typedef enum logic [2:0] {
    STANDBY  = 3'd0,
    PLAYING  = 3'd1,
    POWER    = 3'd2,
    DYING    = 3'd3,
    GAMEOVER = 3'd4,
    WIN      = 3'd5
  } state_t;

  localparam int PW  = $clog2(POWER_TICKS + 1);
  localparam int DTW = $clog2(DEATH_TICKS + 1);
  localparam int ND  = (SCORE_DIGITS > 4) ? SCORE_DIGITS : 4;
  localparam int AW  = 4 * ND;

  state_t                    state_q;
  logic                      startLatch_q;
  logic [LW-1:0]             lives_q;
  logic [DW-1:0]             dots_q;
  logic [PW-1:0]             powerCnt_q;
  logic [DTW-1:0]            deathCnt_q;
  logic [4*SCORE_DIGITS-1:0] score_q;
  logic                      pendDotV_q;
  logic [15:0]               pendAmt_q;
  logic [NUM_GHOSTS-1:0]     pendGhost_q;
  logic                      dotClear_q;
  logic [NUM_GHOSTS-1:0]     ghostResp_q;
  logic                      playerResp_q;
  logic                      overrun_q;

  logic [NUM_GHOSTS-1:0]     hits;
  logic [NUM_GHOSTS-1:0]     pendGhost_d;
  logic [15:0]               addAmt;
  logic [4*SCORE_DIGITS-1:0] score_d;
  logic                      winNow;

  // Unsigned absolute distance on each axis so positions near 0 and the top never wrap into a hit.
  always_comb begin
    hits = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      logic [COORD_W-1:0] gx, gy, dx, dy;
      gx = ghost_x[i*COORD_W +: COORD_W];
      gy = ghost_y[i*COORD_W +: COORD_W];
      dx = (gx > player_x) ? gx - player_x : player_x - gx;
      dy = (gy > player_y) ? gy - player_y : player_y - gy;
      hits[i] = (dx < COORD_W'(TILE_SIZE)) && (dy < COORD_W'(TILE_SIZE));
    end
  end

  // The dot award drains first, then ghosts from the lowest index upward.
  always_comb begin
    logic found;
    found       = 1'b0;
    addAmt      = 16'h0000;
    pendGhost_d = pendGhost_q;
    if (pendDotV_q) begin
      addAmt = pendAmt_q;
    end else begin
      for (int i = 0; i < NUM_GHOSTS; i++) begin
        if (pendGhost_q[i] && !found) begin
          found          = 1'b1;
          pendGhost_d[i] = 1'b0;
          addAmt         = GHOST_PTS_BCD;
        end
      end
    end
  end

  // Decimal ripple add; any carry beyond the displayed digits pins the score at all nines.
  always_comb begin
    logic [AW-1:0] aExt, bExt, sumExt;
    logic [4:0]    dsum;
    logic          carry, ovf;
    aExt   = AW'(score_q);
    bExt   = AW'(addAmt);
    sumExt = '0;
    carry  = 1'b0;
    for (int i = 0; i < ND; i++) begin
      dsum = {1'b0, aExt[4*i +: 4]} + {1'b0, bExt[4*i +: 4]} + {4'b0000, carry};
      if (dsum > 5'd9) begin
        dsum  = dsum + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sumExt[4*i +: 4] = dsum[3:0];
    end
    ovf = carry;
    for (int i = SCORE_DIGITS; i < ND; i++) begin
      if (sumExt[4*i +: 4] != 4'h0) ovf = 1'b1;
    end
    score_d = ovf ? {SCORE_DIGITS{4'h9}} : sumExt[4*SCORE_DIGITS-1:0];
  end

  assign busy   = pendDotV_q | (|pendGhost_q);
  assign winNow = (dot_hit || bigdot_hit) && (dots_q + 1'b1 == DW'(MAX_DOTS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= STANDBY;
      startLatch_q <= 1'b0;
      lives_q      <= LW'(LIVES);
      dots_q       <= '0;
      powerCnt_q   <= '0;
      deathCnt_q   <= '0;
      score_q      <= '0;
      pendDotV_q   <= 1'b0;
      pendAmt_q    <= 16'h0000;
      pendGhost_q  <= '0;
      dotClear_q   <= 1'b0;
      ghostResp_q  <= '0;
      playerResp_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      dotClear_q   <= 1'b0;
      ghostResp_q  <= '0;
      playerResp_q <= 1'b0;
      if (start) startLatch_q <= 1'b1;
      if (tick && busy) overrun_q <= 1'b1;

      if (busy) begin
        score_q <= score_d;
        if (pendDotV_q) pendDotV_q  <= 1'b0;
        else            pendGhost_q <= pendGhost_d;
      end else if (tick) begin
        case (state_q)
          STANDBY: begin
            if (startLatch_q) begin
              state_q      <= PLAYING;
              startLatch_q <= 1'b0;
            end
          end
          PLAYING, POWER: begin
            if (state_q == PLAYING && (|hits)) begin
              lives_q <= lives_q - 1'b1;
              if (lives_q == LW'(1)) begin
                state_q <= GAMEOVER;
              end else begin
                state_q      <= DYING;
                deathCnt_q   <= '0;
                playerResp_q <= 1'b1;
                ghostResp_q  <= '1;
              end
            end else begin
              if (state_q == POWER) begin
                ghostResp_q <= hits;
                pendGhost_q <= hits;
              end
              if (dot_hit || bigdot_hit) begin
                dotClear_q <= 1'b1;
                dots_q     <= dots_q + 1'b1;
                pendDotV_q <= 1'b1;
                pendAmt_q  <= dot_hit ? DOT_PTS_BCD : BIGDOT_PTS_BCD;
              end
              if (!dot_hit && bigdot_hit) begin
                state_q    <= POWER;
                powerCnt_q <= PW'(POWER_TICKS);
              end else if (state_q == POWER) begin
                powerCnt_q <= powerCnt_q - 1'b1;
                if (powerCnt_q == PW'(1)) state_q <= PLAYING;
              end
              if (winNow) state_q <= WIN;
            end
          end
          DYING: begin
            if (deathCnt_q == DTW'(DEATH_TICKS - 1)) begin
              state_q    <= PLAYING;
              deathCnt_q <= '0;
            end else begin
              deathCnt_q <= deathCnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign game_state     = state_q;
  assign dot_clear      = dotClear_q;
  assign ghost_respawn  = ghostResp_q;
  assign player_respawn = playerResp_q;
  assign score_bcd      = score_q;
  assign lives          = lives_q;
  assign dots_eaten     = dots_q;
  assign tick_overrun   = overrun_q;

endmodule

// File: tb/tb_game_referee.sv
// Directed bench for game_referee, built with a 3-digit score so saturation is reachable
// by eating dots; expected values are hand-computed BCD/state constants.
module tb_game_referee;

  logic        clk = 1'b0;
  logic        reset, tick, start, dotHit, bigdotHit;
  logic [9:0]  playerX, playerY;
  logic [39:0] ghostX, ghostY;
  logic [2:0]  gameState;
  logic        dotClear, playerRespawn, busy, tickOverrun;
  logic [3:0]  ghostRespawn;
  logic [11:0] scoreBcd;
  logic [1:0]  lives;
  logic [8:0]  dotsEaten;

  int testsRun = 0;
  int testsFailed = 0;

  game_referee #(.SCORE_DIGITS(3)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .player_x(playerX), .player_y(playerY), .ghost_x(ghostX), .ghost_y(ghostY),
    .dot_hit(dotHit), .bigdot_hit(bigdotHit), .game_state(gameState),
    .dot_clear(dotClear), .ghost_respawn(ghostRespawn), .player_respawn(playerRespawn),
    .score_bcd(scoreBcd), .lives(lives), .dots_eaten(dotsEaten), .busy(busy),
    .tick_overrun(tickOverrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One tick cycle with the given tile lookups; returns mid-cycle T+1.
  task automatic applyStimulus(input logic dot, input logic big);
    @(negedge clk);
    tick = 1'b1; dotHit = dot; bigdotHit = big;
    @(negedge clk);
    tick = 1'b0; dotHit = 1'b0; bigdotHit = 1'b0;
  endtask

  task automatic setGhost(input int idx, input logic [9:0] x, input logic [9:0] y);
    ghostX[idx*10 +: 10] = x;
    ghostY[idx*10 +: 10] = y;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle", 32'(busy), 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tick = 0; start = 0; dotHit = 0; bigdotHit = 0;
    playerX = 10'd100; playerY = 10'd100;
    for (int i = 0; i < 4; i++) setGhost(i, 10'd500, 10'd500);
    doReset();
    checkOutput("rst_state", 32'(gameState), 32'd0);
    checkOutput("rst_lives", 32'(lives), 32'd3);
    checkOutput("rst_score", 32'(scoreBcd), 32'h000);
    checkOutput("rst_dots", 32'(dotsEaten), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overrun", 32'(tickOverrun), 32'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("start_state", 32'(gameState), 32'd1);
    checkOutput("start_lives", 32'(lives), 32'd3);

    applyStimulus(1'b1, 1'b0);
    checkOutput("dot_clear", 32'(dotClear), 32'd1);
    checkOutput("dot_busy", 32'(busy), 32'd1);
    checkOutput("dot_count", 32'(dotsEaten), 32'd1);
    @(negedge clk);
    checkOutput("dot_score", 32'(scoreBcd), 32'h010);
    checkOutput("dot_busy_done", 32'(busy), 32'd0);
    checkOutput("dot_clear_pulse", 32'(dotClear), 32'd0);

    applyStimulus(1'b0, 1'b1);
    checkOutput("big_state", 32'(gameState), 32'd2);
    checkOutput("big_clear", 32'(dotClear), 32'd1);
    waitIdle();
    checkOutput("big_score", 32'(scoreBcd), 32'h060);

    setGhost(0, 10'd105, 10'd105);
    setGhost(2, 10'd105, 10'd105);
    applyStimulus(1'b0, 1'b0);
    checkOutput("eat_state", 32'(gameState), 32'd2);
    checkOutput("eat_respawn", 32'(ghostRespawn), 32'b0101);
    checkOutput("eat_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("eat_busy2", 32'(busy), 32'd1);
    checkOutput("eat_score1", 32'(scoreBcd), 32'h260);
    @(negedge clk);
    checkOutput("eat_busy3", 32'(busy), 32'd0);
    checkOutput("eat_score2", 32'(scoreBcd), 32'h460);
    setGhost(0, 10'd500, 10'd500);
    setGhost(2, 10'd500, 10'd500);

    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b0, 1'b0);
      if (i == 8) checkOutput("power_hold", 32'(gameState), 32'd2);
    end
    checkOutput("power_end", 32'(gameState), 32'd1);

    setGhost(1, 10'd116, 10'd100);
    applyStimulus(1'b0, 1'b0);
    checkOutput("dx16_state", 32'(gameState), 32'd1);
    checkOutput("dx16_lives", 32'(lives), 32'd3);
    setGhost(1, 10'd115, 10'd100);
    applyStimulus(1'b0, 1'b0);
    checkOutput("dx15_state", 32'(gameState), 32'd3);
    checkOutput("dx15_lives", 32'(lives), 32'd2);
    checkOutput("dx15_grsp", 32'(ghostRespawn), 32'hF);
    checkOutput("dx15_prsp", 32'(playerRespawn), 32'd1);
    setGhost(1, 10'd500, 10'd500);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (i == 3) checkOutput("dying_hold", 32'(gameState), 32'd3);
    end
    checkOutput("dying_end", 32'(gameState), 32'd1);
    checkOutput("dying_dots", 32'(dotsEaten), 32'd2);

    playerX = 10'd1000;
    setGhost(3, 10'd0, 10'd100);
    applyStimulus(1'b0, 1'b0);
    checkOutput("nowrap_state", 32'(gameState), 32'd1);
    playerX = 10'd100;
    setGhost(3, 10'd500, 10'd500);

    setGhost(0, 10'd100, 10'd100);
    applyStimulus(1'b0, 1'b0);
    checkOutput("hit2_state", 32'(gameState), 32'd3);
    checkOutput("hit2_lives", 32'(lives), 32'd1);
    repeat (4) applyStimulus(1'b0, 1'b0);
    checkOutput("hit2_back", 32'(gameState), 32'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("over_state", 32'(gameState), 32'd4);
    checkOutput("over_lives", 32'(lives), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("over_terminal", 32'(gameState), 32'd4);
    checkOutput("over_dots", 32'(dotsEaten), 32'd2);
    setGhost(0, 10'd500, 10'd500);

    doReset();
    checkOutput("rst2_score", 32'(scoreBcd), 32'h000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 99; i++) begin
      applyStimulus(1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("pre_sat_score", 32'(scoreBcd), 32'h990);
    checkOutput("pre_overrun", 32'(tickOverrun), 32'd0);
    applyStimulus(1'b1, 1'b0);
    tick = 1'b1; dotHit = 1'b1;
    @(negedge clk);
    tick = 1'b0; dotHit = 1'b0;
    checkOutput("sat_score", 32'(scoreBcd), 32'h999);
    checkOutput("overrun", 32'(tickOverrun), 32'd1);
    checkOutput("overrun_dots", 32'(dotsEaten), 32'd100);

    for (int i = 1; i <= 200; i++) begin
      applyStimulus(1'b1, 1'b0);
      @(negedge clk);
      if (i == 199) checkOutput("prewin_state", 32'(gameState), 32'd1);
    end
    checkOutput("win_state", 32'(gameState), 32'd5);
    checkOutput("win_dots", 32'(dotsEaten), 32'd300);
    checkOutput("win_score", 32'(scoreBcd), 32'h999);

    doReset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    waitIdle();
    setGhost(0, 10'd100, 10'd100);
    setGhost(2, 10'd100, 10'd100);
    applyStimulus(1'b0, 1'b0);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_busy_clr", 32'(busy), 32'd0);
    checkOutput("mid_score", 32'(scoreBcd), 32'h000);
    checkOutput("mid_state", 32'(gameState), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
